// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, sign fix-up in a final step.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             kill_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                neg_a_q, neg_a_d;
  logic                neg_b_q, neg_b_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [XLEN-1:0]     opnd_q, opnd_d;
  // Multiply: {product high, product low / remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [TAG_W-1:0]    tag_out_q, tag_out_d;

  logic                sign_a_en, sign_b_en;
  logic                neg_a, neg_b;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_zero, div_ovf;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift, div_diff;
  logic                div_ge;
  logic [XLEN-1:0]     div_rem;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix;

  // Operand decode at acceptance: signedness per opcode, magnitudes, special cases.
  assign sign_a_en = (funct3_i == 3'b001) | (funct3_i == 3'b010) |
                     (funct3_i == 3'b100) | (funct3_i == 3'b110);
  assign sign_b_en = (funct3_i == 3'b001) | (funct3_i == 3'b100) | (funct3_i == 3'b110);
  assign neg_a     = sign_a_en & rs1_i[XLEN-1];
  assign neg_b     = sign_b_en & rs2_i[XLEN-1];
  assign a_mag     = neg_a ? -rs1_i : rs1_i;
  assign b_mag     = neg_b ? -rs2_i : rs2_i;
  assign div_zero  = funct3_i[2] & (rs2_i == '0);
  assign div_ovf   = funct3_i[2] & ~funct3_i[0] &
                     (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);

  // One iteration datapaths.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                     (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = ~div_diff[XLEN];
  assign div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];

  // Sign correction; special cases enter FIX with both sign flags cleared.
  assign prod_fix  = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quo_fix   = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix   = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  // Next-state logic; kill overrides acceptance and completion.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    tag_d     = tag_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    tag_out_d = tag_out_q;
    if (kill_i) begin
      state_d = StIdle;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            op_d   = funct3_i;
            tag_d  = tag_i;
            cnt_d  = '0;
            busy_d = 1'b1;
            if (div_zero) begin
              acc_d   = {rs1_i, {XLEN{1'b1}}};
              neg_a_d = 1'b0;
              neg_b_d = 1'b0;
              state_d = StFix;
            end else if (div_ovf) begin
              acc_d   = {{XLEN{1'b0}}, rs1_i};
              neg_a_d = 1'b0;
              neg_b_d = 1'b0;
              state_d = StFix;
            end else begin
              neg_a_d = neg_a;
              neg_b_d = neg_b;
              state_d = StCalc;
              if (funct3_i[2]) begin
                opnd_d = b_mag;
                acc_d  = {{XLEN{1'b0}}, a_mag};
              end else begin
                opnd_d = a_mag;
                acc_d  = {{XLEN{1'b0}}, b_mag};
              end
            end
          end
        end
        StCalc: begin
          cnt_d = cnt_q + 1'b1;
          if (op_q[2]) acc_d = {div_rem, acc_q[XLEN-2:0], div_ge};
          else         acc_d = {mul_sum, acc_q[XLEN-1:1]};
          if (cnt_q == CntW'(XLEN - 1)) state_d = StFix;
        end
        StFix: begin
          state_d   = StIdle;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          tag_out_d = tag_q;
          unique case (op_q)
            3'b000:                 result_d = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result_d = quo_fix;
            default:                result_d = rem_fix;
          endcase
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      tag_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      tag_out_q <= tag_out_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign tag_o    = tag_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes reference results at
// acceptance, a negedge monitor pops and compares on every done_o pulse.
module tb_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic             kill_i;
  logic [2:0]       funct3_i;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic [TAG_W-1:0] tag_i;
  logic             busy_o;
  logic             done_o;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .kill_i   (kill_i),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .tag_i    (tag_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .tag_o    (tag_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    int               lat;
    int               acc;
  } exp_t;

  exp_t             sbq[$];
  exp_t             mon_e;
  logic [XLEN-1:0]  last_res = '0;
  logic [TAG_W-1:0] last_tag = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the RISC-V M-extension definitions.
  function automatic logic [XLEN-1:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                                input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    case (f)
      3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hffff_ffff) return a;
        return ia / ib;
      end
      3'b101: return (b == 0) ? '1 : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hffff_ffff) return '0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hffff_ffff));
  endfunction

  task automatic push_exp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t);
    exp_t e;
    e.res = ref_model(f, a, b);
    e.tag = t;
    e.lat = is_special(f, a, b) ? 1 : XLEN + 1;
    e.acc = cyc;
    sbq.push_back(e);
  endtask

  // Present a request at an idle unit; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input bit hold);
    int n = 0;
    while (busy_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    funct3_i = f;
    rs1_i    = a;
    rs2_i    = b;
    tag_i    = t;
    start_i  = 1'b1;
    @(posedge clk); #1;
    check("accept_busy", busy_o, 1);
    push_exp(f, a, b, t);
    if (!hold) begin
      start_i  = 1'b0;
      // Captured operands must not follow later input changes.
      rs1_i    = $urandom;
      rs2_i    = $urandom;
      funct3_i = 3'($urandom);
      tag_i    = 5'($urandom);
    end
  endtask

  task automatic wait_done(output int busy_cycles);
    int n = 0;
    busy_cycles = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done_o) break;
      if (busy_o) busy_cycles++;
    end
    if (!done_o) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done_o after %0d cycles required done_o=1", n);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst_i && done_o) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done_o=1 result 0x%0h required no done_o", result_o);
      end else begin
        mon_e = sbq.pop_front();
        check("result", result_o, mon_e.res);
        check("tag", tag_o, mon_e.tag);
        check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
        check("busy_at_done", busy_o, 0);
        last_res = mon_e.res;
        last_tag = mon_e.tag;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1);
  end

  logic [2:0]  dir_f[15];
  logic [31:0] dir_a[15];
  logic [31:0] dir_b[15];

  initial begin
    int bc;
    dir_f = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111,
              3'b101, 3'b110, 3'b100, 3'b110, 3'b100, 3'b000, 3'b001};
    dir_a = '{32'd7, 32'h8000_0000, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fff9,
              32'hffff_fff9, 32'd100, 32'd100, 32'h1234, 32'h1234, 32'h8000_0000,
              32'h8000_0000, 32'h8000_0000, 32'hdead_beef, 32'h7fff_ffff};
    dir_b = '{32'hffff_fffd, 32'h8000_0000, 32'hffff_ffff, 32'hffff_ffff, 32'd2, 32'd2,
              32'd7, 32'd7, 32'd0, 32'd0, 32'hffff_ffff, 32'hffff_ffff, 32'd1,
              32'hcafe_f00d, 32'h8000_0001};

    rst_i    = 1'b1;
    start_i  = 1'b0;
    kill_i   = 1'b0;
    funct3_i = '0;
    rs1_i    = '0;
    rs2_i    = '0;
    tag_i    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy_o, done_o, result_o, tag_o}, 0);
    rst_i = 1'b0;

    // MUL 7 * -3: busy for every cycle between accept and done.
    issue(3'b000, 32'd7, 32'hffff_fffd, 5'd5, 1'b0);
    wait_done(bc);
    check("mul_busy_cycles", bc, 32);

    for (int i = 1; i < 15; i++) begin
      issue(dir_f[i], dir_a[i], dir_b[i], 5'(i), 1'b0);
      wait_done(bc);
    end

    // Kill on the 10th CALC edge: no done_o, outputs keep previous values.
    issue(3'b000, 32'h0001_2345, 32'h0000_0777, 5'd7, 1'b0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    void'(sbq.pop_back());
    check("kill_busy", busy_o, 0);
    check("kill_done", done_o, 0);
    check("kill_result_held", result_o, last_res);
    check("kill_tag_held", tag_o, last_tag);
    repeat (40) @(posedge clk);
    #1;
    issue(3'b000, 32'd3, 32'd4, 5'd3, 1'b0);
    wait_done(bc);

    // start_i held through done_o: next request accepted in the done cycle.
    issue(3'b101, 32'd100, 32'd7, 5'd9, 1'b1);
    funct3_i = 3'b000;
    rs1_i    = 32'd3;
    rs2_i    = 32'd5;
    tag_i    = 5'd10;
    wait_done(bc);
    @(posedge clk); #1;
    check("b2b_accept", busy_o, 1);
    push_exp(3'b000, 32'd3, 32'd5, 5'd10);
    start_i = 1'b0;
    wait_done(bc);

    // start_i pulsed while busy is ignored.
    issue(3'b101, 32'd1000, 32'd3, 5'd1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    funct3_i = 3'b000;
    rs1_i    = 32'd9;
    rs2_i    = 32'd9;
    tag_i    = 5'd2;
    start_i  = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done(bc);
    repeat (3) @(posedge clk);
    #1;
    check("ignored_start_idle", busy_o, 0);

    // Asynchronous reset mid-CALC clears outputs at once, no done_o follows.
    issue(3'b100, 32'h7654_3210, 32'd13, 5'd17, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_i = 1'b1;
    #1;
    check("rst_async_outputs", {busy_o, done_o, result_o, tag_o}, 0);
    void'(sbq.pop_back());
    @(posedge clk); #1;
    rst_i = 1'b0;
    last_res = '0;
    last_tag = '0;
    repeat (40) @(posedge clk);
    #1;
    check("rst_no_busy", busy_o, 0);

    // Randomised operations with a bias towards the division corner cases.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      int          r;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) b = '0;
      else if (r == 1) begin
        a = 32'h8000_0000;
        b = 32'hffff_ffff;
      end else if (r == 2) b = 32'($urandom_range(1, 20));
      else if (r == 3) a = 32'h8000_0000;
      issue(f, a, b, 5'($urandom), 1'b0);
      wait_done(bc);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle RV32M/RV64M execute unit beside the single-cycle ALU in the EX stage.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU by iterative shift-add and restoring division, one bit per cycle.
- Reports busy_o so the hazard logic can stall IF/ID/EX.
- Returns the result with its destination-register tag on a one-cycle done_o pulse; a kill input aborts on flush.

Parameters:
- XLEN, 32, operand and result width (32 or 64).
- TAG_W, 5, width of the destination-register tag carried alongside the operation.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  request; accepted only in IDLE.
- kill_i  input  1  abort current operation (pipeline flush).
- funct3_i  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_i  input  XLEN  operand A (multiplicand/dividend).
- rs2_i  input  XLEN  operand B (multiplier/divisor).
- tag_i  input  TAG_W  destination register address.
- busy_o  output  1  operation in flight.
- done_o  output  1  one-cycle result-valid pulse.
- result_o  output  XLEN  result; held until next done.
- tag_o  output  TAG_W  tag of result_o; held with it.

Behaviour:
- Reset (async, rst_i=1): state IDLE, busy_o=0, done_o=0, result_o=0, tag_o=0, all internal registers 0. Reset mid-operation discards the operation; no done_o follows.
- States: IDLE, CALC, FIX.
- IDLE: on an edge with start_i=1 and kill_i=0, latch funct3_i, tag_i, operand magnitudes and sign flags.
  - MUL/MULHU: both operands unsigned.
  - MULH: both signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV/REM: both signed.
  - DIVU/REMU: both unsigned.
  - Then go to CALC with count=0. Special cases go directly to FIX instead:
    - Divide by zero (rs2=0, any div/rem op).
    - Signed overflow (DIV/REM with rs1=most-negative and rs2=-1).
- CALC: each edge performs one iteration and increments count.
  - Multiply: 2*XLEN-bit unsigned product accumulator.
  - Divide: restoring divide on magnitudes, XLEN-bit quotient and remainder.
  - After XLEN iterations (count = XLEN-1 on the edge), go to FIX.
- FIX: one edge.
  - Apply sign correction. Product is negated if the operand signs differ, applied only to signed-operand positions. Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
  - Select result: MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits; DIV/DIVU quotient; REM/REMU remainder.
  - Divide by zero: quotient all-ones, remainder = rs1.
  - Overflow: quotient = rs1, remainder = 0.
  - Register result_o and tag_o, assert done_o for exactly one cycle, return to IDLE.
- Latency, counted from the accepting edge to the edge that raises done_o:
  - Normal operation: XLEN+1 edges (33 for XLEN=32).
  - Special case: 1 edge.
- busy_o is registered. It is 1 from the accepting edge until the edge raising done_o, where it falls to 0 concurrently with done_o rising.
- start_i while busy_o=1 is ignored; the requester holds start_i until it sees busy_o.
- start_i is legal in the done_o cycle. The unit is in IDLE, so it accepts the request, and busy_o rises at the next edge.
- kill_i=1 on any edge: return to IDLE, busy_o=0, no done_o.
  - kill_i has priority over start_i and over the FIX completion.
  - result_o and tag_o keep their previous values.
- Operands are captured at acceptance. Later changes on rs1_i/rs2_i/funct3_i/tag_i have no effect.
- All arithmetic is exact at XLEN/2*XLEN widths; there is no truncation before result selection.

Test Plan:
- MUL, rs1=7, rs2=0xFFFFFFFD (-3), tag=5 -> done_o 33 edges after accept; result_o=0xFFFFFFEB, tag_o=5; busy_o=1 for the 32 intervening cycles.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7,2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF, and REM 0x1234/0 -> 0x1234, each with done_o 1 edge after accept. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, and REM of the same operands -> 0, each in 1 edge.
- kill_i at the 10th CALC edge -> busy_o=0 next cycle, no done_o, result_o unchanged. A following start with MUL 3*4 -> 12 after 33 edges.
- Back-to-back:
  - start_i held high through done_o -> second operation accepted in the done cycle.
  - start_i pulsed while busy -> ignored.
  - rst_i pulsed mid-CALC -> all outputs 0 immediately, no done_o.
